power_seq: RTL and testbench

Multi-rail power sequencer that sits directly downstream of `power_on` and consumes its `enable` output. While `enable` is high it turns on `N_RAILS` supply rails in ascending index order. Each rail must report its own power-good before the next rail is started. When `enable` falls it turns the rails off in reverse order. Faults (a rail that never comes up, or a good rail that drops) shut all rails off at once and latch until software clears them.

---
 rtl/power_seq.sv | 231 +++++++++++++++++++++++
 tb/tb_power_seq.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/power_seq.sv
// Multi-rail power sequencer: ascending ramp-up gated on per-rail power-good, reverse ramp-down, latched faults.
// Optional RAMP_UP timeout is compiled in when POWER_SEQ_TIMEOUT_EN is defined.
module power_seq #(
  parameter int N_RAILS     = 4,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 100
) (
  input  logic               clk,
  input  logic               resetb,
  input  logic               enable,
  input  logic [N_RAILS-1:0] rail_pg,
  input  logic               clear_fault,
  output logic [N_RAILS-1:0] rail_en,
  output logic               all_good,
  output logic               busy,
  output logic               fault,
  output logic [N_RAILS-1:0] fault_rail
);

`ifdef POWER_SEQ_TIMEOUT_EN
  localparam int CNT_MAX = (SETTLE_CYC > TIMEOUT_CYC) ? SETTLE_CYC : TIMEOUT_CYC;
`else
  localparam int CNT_MAX = SETTLE_CYC;
`endif
  localparam int CW = $clog2(CNT_MAX + 1);
  localparam int IW = $clog2(N_RAILS);
  localparam logic [CW-1:0] CNT_SAT     = CW'(CNT_MAX);
  localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYC - 1);
`ifdef POWER_SEQ_TIMEOUT_EN
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYC - 1);
`endif
  localparam logic [IW-1:0] IDX_LAST = IW'(N_RAILS - 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RAMP_UP,
    ST_SETTLE,
    ST_ON,
    ST_RAMP_DOWN,
    ST_FAULT
  } state_t;

  logic [N_RAILS-1:0] pg_s;

  for (genvar gi = 0; gi < N_RAILS; gi++) begin : g_sync
    logic meta_reg;
    logic sync_reg;
    always_ff @(posedge clk or negedge resetb) begin
      if (!resetb) begin
        meta_reg <= 1'b0;
        sync_reg <= 1'b0;
      end else begin
        meta_reg <= rail_pg[gi];
        sync_reg <= meta_reg;
      end
    end
    assign pg_s[gi] = sync_reg;
  end

  state_t             state_reg, state_next;
  logic [IW-1:0]      idx_reg, idx_next;
  logic [CW-1:0]      cnt_reg, cnt_next;
  logic [N_RAILS-1:0] rail_en_reg, rail_en_next;
  logic [N_RAILS-1:0] fault_rail_reg, fault_rail_next;
  logic               all_good_reg, all_good_next;
  logic               busy_reg, busy_next;
  logic               fault_reg, fault_next;

  logic [N_RAILS-1:0] idx_oh;
  logic [N_RAILS-1:0] drop_mask;
  logic [N_RAILS-1:0] drop_low;
  logic [CW-1:0]      cnt_inc;

  assign idx_oh   = N_RAILS'(1) << idx_reg;
  assign drop_low = drop_mask & (~drop_mask + N_RAILS'(1));
  assign cnt_inc  = (cnt_reg == CNT_SAT) ? cnt_reg : cnt_reg + CW'(1);

  // Only rails already sequenced are watched; rail idx itself is still ramping.
  always_comb begin
    drop_mask = '0;
    case (state_reg)
      ST_RAMP_UP, ST_SETTLE: drop_mask = ~pg_s & (idx_oh - N_RAILS'(1));
      ST_ON:                 drop_mask = ~pg_s;
      default:               drop_mask = '0;
    endcase
  end

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      state_reg      <= ST_IDLE;
      idx_reg        <= '0;
      cnt_reg        <= '0;
      rail_en_reg    <= '0;
      fault_rail_reg <= '0;
      all_good_reg   <= 1'b0;
      busy_reg       <= 1'b0;
      fault_reg      <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      cnt_reg        <= cnt_next;
      rail_en_reg    <= rail_en_next;
      fault_rail_reg <= fault_rail_next;
      all_good_reg   <= all_good_next;
      busy_reg       <= busy_next;
      fault_reg      <= fault_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    idx_next        = idx_reg;
    cnt_next        = cnt_reg;
    rail_en_next    = rail_en_reg;
    fault_rail_next = fault_rail_reg;

    unique case (state_reg)
      ST_IDLE: begin
        rail_en_next    = '0;
        fault_rail_next = '0;
        if (enable) begin
          state_next   = ST_RAMP_UP;
          idx_next     = '0;
          cnt_next     = '0;
          rail_en_next = N_RAILS'(1);
        end
      end

      ST_RAMP_UP: begin
        if (|drop_mask) begin
          state_next      = ST_FAULT;
          rail_en_next    = '0;
          fault_rail_next = drop_low;
        end else if (!enable) begin
          state_next   = ST_RAMP_DOWN;
          rail_en_next = rail_en_reg & ~idx_oh;
          cnt_next     = '0;
        end else if (|(pg_s & idx_oh)) begin
          state_next = ST_SETTLE;
          cnt_next   = '0;
        end
`ifdef POWER_SEQ_TIMEOUT_EN
        else if (cnt_reg == TIMEOUT_LAST) begin
          state_next      = ST_FAULT;
          rail_en_next    = '0;
          fault_rail_next = idx_oh;
        end else begin
          cnt_next = cnt_inc;
        end
`endif
      end

      ST_SETTLE: begin
        if (|drop_mask) begin
          state_next      = ST_FAULT;
          rail_en_next    = '0;
          fault_rail_next = drop_low;
        end else if (!enable) begin
          state_next   = ST_RAMP_DOWN;
          rail_en_next = rail_en_reg & ~idx_oh;
          cnt_next     = '0;
        end else if (cnt_reg == SETTLE_LAST) begin
          cnt_next = '0;
          if (idx_reg == IDX_LAST) begin
            state_next = ST_ON;
          end else begin
            state_next   = ST_RAMP_UP;
            idx_next     = idx_reg + IW'(1);
            rail_en_next = rail_en_reg | (idx_oh << 1);
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_ON: begin
        if (|drop_mask) begin
          state_next      = ST_FAULT;
          rail_en_next    = '0;
          fault_rail_next = drop_low;
        end else if (!enable) begin
          state_next   = ST_RAMP_DOWN;
          idx_next     = IDX_LAST;
          rail_en_next = rail_en_reg & ~idx_oh;
          cnt_next     = '0;
        end
      end

      // Rail idx is already off; after the settle gap, drop the next one down.
      ST_RAMP_DOWN: begin
        if (cnt_reg == SETTLE_LAST) begin
          cnt_next = '0;
          if (idx_reg == '0) begin
            state_next   = ST_IDLE;
            rail_en_next = '0;
          end else begin
            idx_next     = idx_reg - IW'(1);
            rail_en_next = rail_en_reg & ~(idx_oh >> 1);
          end
        end else begin
          cnt_next = cnt_inc;
        end
      end

      ST_FAULT: begin
        rail_en_next = '0;
        if (clear_fault && !enable) begin
          state_next      = ST_IDLE;
          fault_rail_next = '0;
        end
      end

      default: begin
        state_next   = ST_IDLE;
        rail_en_next = '0;
      end
    endcase

    all_good_next = (state_next == ST_ON);
    busy_next     = (state_next == ST_RAMP_UP) || (state_next == ST_SETTLE) ||
                    (state_next == ST_RAMP_DOWN);
    fault_next    = (state_next == ST_FAULT);
  end

  assign rail_en    = rail_en_reg;
  assign fault_rail = fault_rail_reg;
  assign all_good   = all_good_reg;
  assign busy       = busy_reg;
  assign fault      = fault_reg;

endmodule

// File: tb/tb_power_seq.sv
// Bench for power_seq: regulator model with random power-good delays, expected waveforms
// derived as per-rail on/off edge times computed from the sequencing rules.
module tb_power_seq;
  localparam int N   = 4;
  localparam int S   = 16;
  localparam int T   = 100;
  localparam int INF = 32'h3fff_ffff;

  logic         clk = 1'b0;
  logic         resetb;
  logic         enable;
  logic         clear_fault;
  logic [N-1:0] rail_pg;
  logic [N-1:0] rail_en;
  logic         all_good;
  logic         busy;
  logic         fault;
  logic [N-1:0] fault_rail;

  power_seq #(.N_RAILS(N), .SETTLE_CYC(S), .TIMEOUT_CYC(T)) dut (
    .clk        (clk),
    .resetb     (resetb),
    .enable     (enable),
    .rail_pg    (rail_pg),
    .clear_fault(clear_fault),
    .rail_en    (rail_en),
    .all_good   (all_good),
    .busy       (busy),
    .fault      (fault),
    .fault_rail (fault_rail)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_bad   = 0;
  int cyc     = 0;
  int on_t[N];
  int off_t[N];
  int dly[N];
  int on_cnt[N];
  int busy_lo, busy_hi, ag_lo, ag_hi, t_on;
  bit sched_en = 1'b0;
  logic [N-1:0] kill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Regulator: power-good follows rail_en after dly cycles unless the rail is killed.
  task automatic set_pg();
    for (int i = 0; i < N; i++) rail_pg[i] = (on_cnt[i] >= dly[i]) && !kill[i];
  endtask

  task automatic check_sched();
    logic [N-1:0] exp_en;
    logic         exp_busy, exp_ag;
    for (int i = 0; i < N; i++) exp_en[i] = (cyc >= on_t[i]) && (cyc < off_t[i]);
    exp_busy = (cyc >= busy_lo) && (cyc < busy_hi);
    exp_ag   = (cyc >= ag_lo) && (cyc < ag_hi);
    chk("rail_en", 32'(rail_en), 32'(exp_en));
    chk("status", 32'({busy, all_good, fault, fault_rail}),
        32'({exp_busy, exp_ag, 1'b0, {N{1'b0}}}));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (sched_en) check_sched();
    for (int i = 0; i < N; i++) on_cnt[i] = rail_en[i] ? on_cnt[i] + 1 : 0;
    set_pg();
  endtask

  task automatic run_to(input int t);
    while (cyc < t) tick();
  endtask

  // Rail 0 rises at r0; each later rail rises 2+S after the previous rail's pg is first sampled.
  task automatic plan_up(input int r0);
    int t;
    t = r0;
    for (int i = 0; i < N; i++) begin
      on_t[i]  = t;
      off_t[i] = INF;
      t = t + dly[i] + 2 + S;
    end
    t_on     = t;
    busy_lo  = r0;
    busy_hi  = t;
    ag_lo    = t;
    ag_hi    = INF;
    sched_en = 1'b1;
  endtask

  task automatic plan_down(input int k, input int top);
    for (int i = 0; i < N; i++) begin
      if (i <= top) off_t[i] = k + (top - i) * S;
      else          on_t[i]  = INF;
    end
    busy_lo = k;
    busy_hi = k + (top + 1) * S;
    ag_hi   = k;
  endtask

  task automatic go_up();
    plan_up(cyc + 1);
    enable = 1'b1;
    run_to(t_on + 1);
    chk("all_good_on", 32'(all_good), 32'd1);
  endtask

  task automatic go_down();
    plan_down(cyc + 1, N - 1);
    enable = 1'b0;
    run_to(busy_hi + 2);
    chk("idle_after_down", 32'({busy, rail_en}), 32'd0);
  endtask

  task automatic drop_test(input logic [N-1:0] kmask);
    int c;
    int lo;
    lo = 0;
    for (int i = N - 1; i >= 0; i--) if (kmask[i]) lo = i;
    c = cyc;
    kill = kmask;
    set_pg();
    run_to(c + 2);
    sched_en = 1'b0;
    tick();
    chk("drop_fault", 32'({fault, busy, all_good, rail_en}), 32'({1'b1, 1'b0, 1'b0, {N{1'b0}}}));
    chk("drop_rail", 32'(fault_rail), 32'd1 << lo);
    kill = '0;
    set_pg();
    $display("drop mask=%b detected at cyc %0d fault_rail=%b", kmask, cyc, fault_rail);
  endtask

  task automatic clear_from_fault();
    enable      = 1'b0;
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("cleared", 32'({fault, fault_rail}), 32'd0);
  endtask

  initial begin
    int j, j1, j2, e1, k, rr, r2, c;
    resetb      = 1'b1;
    enable      = 1'b0;
    clear_fault = 1'b0;
    kill        = '0;
    rail_pg     = '0;
    for (int i = 0; i < N; i++) begin
      dly[i]    = 5;
      on_cnt[i] = 0;
    end
    #2 resetb = 1'b0;
    repeat (3) tick();
    chk("reset_outputs", 32'({rail_en, all_good, busy, fault, fault_rail}), 32'd0);
    resetb = 1'b1;
    tick();
    chk("idle_outputs", 32'({rail_en, all_good, busy, fault, fault_rail}), 32'd0);

    go_up();
    $display("nominal ramp-up reached ON at cyc %0d", cyc);
    go_down();
    $display("nominal ramp-down reached IDLE at cyc %0d", cyc);

    repeat (3) begin
      for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 20);
      go_up();
      repeat ($urandom_range(1, 30)) tick();
      go_down();
      $display("random cycle dly=%0d,%0d,%0d,%0d done at cyc %0d", dly[0], dly[1], dly[2], dly[3], cyc);
    end

    // single rail drop in ON, then clear attempts
    for (int i = 0; i < N; i++) dly[i] = 5;
    go_up();
    j = $urandom_range(0, N - 1);
    drop_test(N'(1) << j);
    clear_fault = 1'b1;
    tick();
    clear_fault = 1'b0;
    chk("clear_ignored", 32'({fault, fault_rail}), 32'({1'b1, N'(1) << j}));
    clear_from_fault();
    $display("fault cleared at cyc %0d", cyc);

    // two rails dropping together: lowest index reported
    go_up();
    j1 = $urandom_range(0, N - 1);
    j2 = (j1 + 1 + $urandom_range(0, N - 2)) % N;
    drop_test((N'(1) << j1) | (N'(1) << j2));
    clear_from_fault();

    // abort during SETTLE after rail 1, re-raise enable during ramp-down
    for (int i = 0; i < N; i++) dly[i] = $urandom_range(1, 20);
    plan_up(cyc + 1);
    enable = 1'b1;
    e1 = on_t[1] + dly[1];
    k  = e1 + 3 + $urandom_range(0, S - 1);
    run_to(k - 1);
    enable = 1'b0;
    plan_down(k, 1);
    rr = k + $urandom_range(0, 2 * S - 2);
    run_to(rr);
    enable = 1'b1;
    run_to(k + 2 * S);
    plan_up(k + 2 * S + 1);
    run_to(t_on + 1);
    chk("restart_on", 32'({all_good, rail_en}), 32'({1'b1, {N{1'b1}}}));
    $display("abort at cyc %0d, restart reached ON at cyc %0d", k, cyc);
    go_down();

    // rail 2 never reports good
    dly[2] = 100000;
    plan_up(cyc + 1);
    enable = 1'b1;
    r2 = on_t[2];
`ifdef POWER_SEQ_TIMEOUT_EN
    run_to(r2 + T - 1);
    sched_en = 1'b0;
    tick();
    chk("timeout_fault", 32'({fault, busy, rail_en}), 32'({1'b1, 1'b0, {N{1'b0}}}));
    chk("timeout_rail", 32'(fault_rail), 32'd4);
    $display("timeout fault at cyc %0d", cyc);
    clear_from_fault();
`else
    run_to(r2 + 1000);
    chk("no_timeout", 32'({fault, busy, rail_en}), 32'({1'b0, 1'b1, 4'b0111}));
    $display("no timeout after 1000 cycles, cyc %0d", cyc);
    plan_down(cyc + 1, 2);
    enable = 1'b0;
    run_to(busy_hi + 2);
    chk("stall_down", 32'({busy, rail_en}), 32'd0);
`endif
    dly[2] = 5;

    // asynchronous reset in the middle of a ramp
    for (int i = 0; i < N; i++) dly[i] = 5;
    plan_up(cyc + 1);
    enable = 1'b1;
    run_to(on_t[1] + 2);
    sched_en = 1'b0;
    c = cyc;
    chk("pre_reset_en", 32'(rail_en), 32'b0011);
    #2;
    resetb = 1'b0;
    enable = 1'b0;
    #1;
    chk("async_reset", 32'({rail_en, all_good, busy, fault, fault_rail}), 32'd0);
    tick();
    resetb = 1'b1;
    tick();
    chk("post_reset_idle", 32'({rail_en, all_good, busy, fault, fault_rail}), 32'd0);
    $display("async reset after cyc %0d cleared outputs", c);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
